// File: rtl/apb_req_master.sv
// APB requester: takes one read/write request on a valid/ready port, runs the
// APB SETUP/ACCESS sequence, and returns PRDATA/PSLVERR on a valid/ready
// response port. An ACCESS phase that stalls too long is aborted with err=1.
//
// Handshakes: a request transfers on a rising HCLK edge where req_valid_i and
// req_ready_o are both 1. A response transfers on an edge where rsp_valid_o and
// rsp_ready_i are both 1. rsp_valid_o/rsp_rdata_o/rsp_err_o stay stable until
// that edge. Only one transfer is outstanding at a time.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      req_write_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic [1:0]                dbg_state
);

  // A zero timeout disables the abort, but the counter keeps one bit so the
  // declarations stay legal.
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                    state_q, state_n;
  logic [CNT_W-1:0]          wait_q, wait_n;
  logic [31:0]               rdata_n;
  logic                      err_n;
  logic [APB_ADDR_WIDTH-1:0] addr_n;
  logic [31:0]               wdata_n;
  logic                      write_n;

  assign req_ready_o = (state_q == ST_IDLE);
  assign dbg_state   = state_q;

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_n = state_q;
    wait_n  = wait_q;
    rdata_n = rsp_rdata_o;
    err_n   = rsp_err_o;
    addr_n  = PADDR;
    wdata_n = PWDATA;
    write_n = PWRITE;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_n = ST_SETUP;
          wait_n  = '0;
          addr_n  = req_addr_i;
          wdata_n = req_wdata_i;
          write_n = req_write_i;
        end
      end
      ST_SETUP: begin
        state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          // A ready slave wins over a timeout firing in the same cycle.
          state_n = ST_RESP;
          rdata_n = PWRITE ? 32'h0 : PRDATA;
          err_n   = PSLVERR;
        end else begin
          if (wait_q != CNT_MAX) wait_n = wait_q + CNT_W'(1);
          if ((TIMEOUT_CYCLES != 0) && (wait_n == CNT_LIMIT)) begin
            state_n = ST_RESP;
            rdata_n = 32'h0;
            err_n   = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_n;
      wait_q  <= wait_n;
    end
  end

  // Registered APB and response outputs, decoded from the next state.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      PADDR       <= addr_n;
      PWDATA      <= wdata_n;
      PWRITE      <= write_n;
      PSEL        <= (state_n == ST_SETUP) || (state_n == ST_ACCESS);
      PENABLE     <= (state_n == ST_ACCESS);
      rsp_valid_o <= (state_n == ST_RESP);
      rsp_rdata_o <= rdata_n;
      rsp_err_o   <= err_n;
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: directed scenarios followed by
// randomized transfers, with the bench acting as the APB slave.
module tb_apb_req_master;

  localparam int AW = 12;
  localparam int TO = 16;

  logic          HCLK;
  logic          HRESETn;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          req_write_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  // Expected responses {err, rdata}, pushed when a request is issued.
  logic [32:0] exp_q[$];

  apb_req_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_write_i(req_write_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state)
  );

  // Clock generation.
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full transfer, starting and ending at a negedge with the DUT idle.
  // waits = PREADY=0 cycles offered before PREADY=1; hold = cycles rsp_ready_i
  // stays low in RESP; noise = keep req_valid_i high (with junk) while busy.
  task automatic run_xfer(input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic wr, input int waits, input logic [31:0] prd,
                          input logic serr, input int hold, input logic noise);
    logic [32:0] exp_rsp;
    int          n_acc;
    // Reference: a slave that stalls TO or more cycles is aborted after TO
    // ACCESS cycles with err=1/rdata=0; otherwise ACCESS lasts waits+1 cycles.
    if (TO != 0 && waits >= TO) begin
      exp_q.push_back({1'b1, 32'h0});
      n_acc = TO;
    end else begin
      exp_q.push_back({serr, wr ? 32'h0 : prd});
      n_acc = waits + 1;
    end
    chk("idle_req_ready", req_ready_o, 1);
    req_valid_i = 1'b1; req_addr_i = addr; req_wdata_i = wdata; req_write_i = wr;
    @(posedge HCLK); @(negedge HCLK);
    req_valid_i = noise; req_addr_i = ~addr; req_wdata_i = ~wdata; req_write_i = ~wr;
    // PREADY is junk here; it must be ignored outside ACCESS.
    PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, addr);
    chk("setup_pwdata", PWDATA, wdata);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_req_ready", req_ready_o, 0);
    chk("setup_rsp_valid", rsp_valid_o, 0);
    @(posedge HCLK);
    for (int k = 0; k < n_acc; k++) begin
      @(negedge HCLK);
      chk("access_psel", PSEL, 1);
      chk("access_penable", PENABLE, 1);
      chk("access_paddr", PADDR, addr);
      chk("access_rsp_valid", rsp_valid_o, 0);
      PREADY  = (k == waits);
      PRDATA  = (k == waits) ? prd : $urandom;
      PSLVERR = (k == waits) ? serr : 1'($urandom_range(0, 1));
      @(posedge HCLK);
    end
    @(negedge HCLK);
    PREADY = 1'b0;
    exp_rsp = exp_q.pop_front();
    chk("resp_valid", rsp_valid_o, 1);
    chk("resp_psel", PSEL, 0);
    chk("resp_penable", PENABLE, 0);
    chk("resp_err", rsp_err_o, exp_rsp[32]);
    chk("resp_rdata", rsp_rdata_o, exp_rsp[31:0]);
    for (int h = 0; h < hold; h++) begin
      rsp_ready_i = 1'b0;
      @(posedge HCLK); @(negedge HCLK);
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_rdata", rsp_rdata_o, exp_rsp[31:0]);
      chk("hold_err", rsp_err_o, exp_rsp[32]);
      chk("hold_req_ready", req_ready_o, 0);
      chk("hold_psel", PSEL, 0);
      chk("hold_paddr", PADDR, addr);
    end
    rsp_ready_i = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    rsp_ready_i = 1'b0; req_valid_i = 1'b0;
    chk("done_rsp_valid", rsp_valid_o, 0);
    chk("done_req_ready", req_ready_o, 1);
    chk("done_psel", PSEL, 0);
    chk("done_paddr_held", PADDR, addr);
  endtask

  initial begin
    HRESETn = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_write_i = 1'b0; rsp_ready_i = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    // Reset state.
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_err", rsp_err_o, 0);

    // Zero-wait write.
    run_xfer(12'h008, 32'hDEADBEEF, 1'b1, 0, 32'h5555AAAA, 1'b0, 0, 1'b0);
    // Read with 3 wait states.
    run_xfer(12'h004, 32'h0, 1'b0, 3, 32'h12345678, 1'b0, 0, 1'b0);
    // Slave error on a read.
    run_xfer(12'h010, 32'h0, 1'b0, 1, 32'hA5A5F00F, 1'b1, 0, 1'b1);
    // Timeouts (read and write) and the just-in-time completion on cycle 16.
    run_xfer(12'h020, 32'h0, 1'b0, 16, 32'h11112222, 1'b0, 0, 1'b0);
    run_xfer(12'h024, 32'h01020304, 1'b1, 25, 32'h33334444, 1'b1, 0, 1'b0);
    run_xfer(12'h028, 32'h0, 1'b0, 15, 32'h77778888, 1'b0, 0, 1'b0);
    // Response back-pressure for 5 cycles with a pending request.
    run_xfer(12'hFFC, 32'h0, 1'b0, 2, 32'hCAFEF00D, 1'b0, 5, 1'b1);

    // Reset in the middle of ACCESS.
    req_valid_i = 1'b1; req_addr_i = 12'h0F0; req_wdata_i = 32'h9; req_write_i = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    req_valid_i = 1'b0; PREADY = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    chk("mid_penable", PENABLE, 1);
    HRESETn = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_rsp_valid", rsp_valid_o, 0);
    chk("mid_rst_req_ready", req_ready_o, 1);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_pwdata", PWDATA, 0);
    chk("mid_rst_rdata", rsp_rdata_o, 0);
    run_xfer(12'h100, 32'h0, 1'b0, 0, 32'hBEEF0001, 1'b0, 0, 1'b0);

    // Randomized transfers.
    for (int n = 0; n < 40; n++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      run_xfer(AW'($urandom), $urandom, 1'($urandom_range(0, 1)), w, $urandom,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
